// File: rtl/spr_re_gamma_pwl.sv
// spr_re_gamma_pwl: multi-channel inverse-gamma using uniform piecewise-linear knot tables.
// Define SPR_RE_GAMMA_SHADOW_EN for double-banked tables swapped atomically at frame end.
module spr_re_gamma_pwl #(
    parameter int CH       = 3,
    parameter int IN_W     = 10,
    parameter int OUT_W    = 11,
    parameter int SEG_LOG2 = 5,
    parameter int KNOT_W   = 12
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_hs,
    input  logic                                 i_vs,
    input  logic                                 en,
    input  logic [CH*IN_W-1:0]                   pix_in,
    output logic [CH*OUT_W-1:0]                  pix_out,
    output logic                                 o_hs,
    output logic                                 o_vs,
    input  logic                                 cfg_we,
    input  logic [(CH > 1 ? $clog2(CH) : 1)-1:0] cfg_ch,
    input  logic [SEG_LOG2:0]                    cfg_addr,
    input  logic [KNOT_W-1:0]                    cfg_data,
    input  logic                                 cfg_commit,
    output logic                                 cfg_busy
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam int FW  = IN_W - SEG_LOG2;
    localparam int NK  = 2**SEG_LOG2 + 1;
    localparam int AW  = SEG_LOG2 + 1;
    localparam int PW  = KNOT_W + 1 + FW;
    localparam int PSW = PW + 1;
    localparam int YW  = (KNOT_W + 3 > OUT_W + 2) ? KNOT_W + 3 : OUT_W + 2;
    localparam logic signed [PSW-1:0] RND   = PSW'(2**(FW-1));
    localparam logic signed [YW-1:0]  Y_MAX = YW'(2**OUT_W - 1);

    function automatic logic [KNOT_W-1:0] ident(input int i);
        return KNOT_W'(i << (OUT_W - SEG_LOG2));
    endfunction

    logic       addr_ok;
    logic       blank;
    logic       swap;
    logic [2:0] hs_sr_reg, vs_sr_reg;
    logic       s1_en_reg, s1_vld_reg, s2_en_reg, s2_vld_reg;

    assign addr_ok = (cfg_addr <= AW'(NK - 1));
    assign blank   = !i_hs || !i_vs;
    assign o_hs    = hs_sr_reg[2];
    assign o_vs    = vs_sr_reg[2];

`ifdef SPR_RE_GAMMA_SHADOW_EN
    logic vs_d_reg, busy_reg;

    // Swap on the edge that first sees i_vs low after it was high.
    assign swap     = busy_reg && vs_d_reg && !i_vs;
    assign cfg_busy = busy_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_d_reg <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            vs_d_reg <= i_vs;
            if (cfg_commit)
                busy_reg <= 1'b1;
            else if (swap)
                busy_reg <= 1'b0;
        end
    end
`else
    logic unused_commit;
    assign unused_commit = cfg_commit;
    assign swap          = 1'b0;
    assign cfg_busy      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_sr_reg  <= '0;
            vs_sr_reg  <= '0;
            s1_en_reg  <= 1'b0;
            s1_vld_reg <= 1'b0;
            s2_en_reg  <= 1'b0;
            s2_vld_reg <= 1'b0;
        end else begin
            hs_sr_reg  <= {hs_sr_reg[1:0], i_hs};
            vs_sr_reg  <= {vs_sr_reg[1:0], i_vs};
            s1_en_reg  <= en && !blank;
            s1_vld_reg <= !blank;
            s2_en_reg  <= s1_en_reg;
            s2_vld_reg <= s1_vld_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [KNOT_W-1:0]      act_mem [NK];
            logic                   we_hit;
            logic [IN_W-1:0]        px;
            logic [SEG_LOG2-1:0]    idx;
            logic [KNOT_W-1:0]      s1_a_reg, s1_b_reg, s2_a_reg;
            logic [FW-1:0]          s1_frac_reg;
            logic [IN_W-1:0]        s1_byp_reg, s2_byp_reg;
            logic signed [KNOT_W:0] d;
            logic signed [FW:0]     fs;
            logic signed [PW-1:0]   p_next, s2_p_reg;
            logic signed [PSW-1:0]  ps;
            logic signed [YW-1:0]   y;
            logic [OUT_W-1:0]       curve, out_next, out_reg;

            assign we_hit = cfg_we && addr_ok && (cfg_ch == CHW'(gi));
            assign px     = pix_in[gi*IN_W +: IN_W];
            assign idx    = px[IN_W-1 -: SEG_LOG2];

`ifdef SPR_RE_GAMMA_SHADOW_EN
            logic [KNOT_W-1:0] shd_mem [NK];

            // The copy reads the pre-write shadow, so a coinciding write waits for the next swap.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < NK; k++) begin
                        act_mem[k] <= ident(k);
                        shd_mem[k] <= ident(k);
                    end
                end else begin
                    if (swap)
                        for (int k = 0; k < NK; k++)
                            act_mem[k] <= shd_mem[k];
                    if (we_hit)
                        shd_mem[cfg_addr] <= cfg_data;
                end
            end
`else
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < NK; k++)
                        act_mem[k] <= ident(k);
                end else if (we_hit) begin
                    act_mem[cfg_addr] <= cfg_data;
                end
            end
`endif

            always_ff @(posedge clk) begin
                if (!rst_n || blank) begin
                    s1_a_reg    <= '0;
                    s1_b_reg    <= '0;
                    s1_frac_reg <= '0;
                    s1_byp_reg  <= '0;
                end else begin
                    s1_a_reg    <= act_mem[AW'(idx)];
                    s1_b_reg    <= act_mem[AW'(idx) + AW'(1)];
                    s1_frac_reg <= px[FW-1:0];
                    s1_byp_reg  <= px;
                end
            end

            assign d      = $signed({1'b0, s1_b_reg}) - $signed({1'b0, s1_a_reg});
            assign fs     = $signed({1'b0, s1_frac_reg});
            assign p_next = PW'(d) * PW'(fs);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s2_p_reg   <= '0;
                    s2_a_reg   <= '0;
                    s2_byp_reg <= '0;
                    out_reg    <= '0;
                end else begin
                    s2_p_reg   <= p_next;
                    s2_a_reg   <= s1_a_reg;
                    s2_byp_reg <= s1_byp_reg;
                    out_reg    <= out_next;
                end
            end

            // Arithmetic shift of the biased product gives round-half-up for both slope signs.
            always_comb begin
                ps    = PSW'(s2_p_reg) + RND;
                y     = YW'($signed({1'b0, s2_a_reg})) + YW'(ps >>> FW);
                curve = y[OUT_W-1:0];
                if (y[YW-1])
                    curve = '0;
                else if (y > Y_MAX)
                    curve = '1;
                out_next = '0;
                if (s2_vld_reg)
                    out_next = s2_en_reg ? curve : (OUT_W'(s2_byp_reg) << (OUT_W - IN_W));
            end

            assign pix_out[gi*OUT_W +: OUT_W] = out_reg;
        end
    endgenerate
endmodule
